operand_narrow: RTL and testbench
=================================

# operand_narrow

Pipelined narrowing unit that converts a DATA_WIDTH signed datapath value into an OPERAND_WIDTH signed operand field. It is the inverse of the operand sign extender. It sits between the accumulator/ALU result path and the instruction/immediate builder, and reports whether the value is representable. A non-representable value is either truncated or saturated, and every such event is counted.

## Interface
- OPERAND_WIDTH, 11, width of the narrowed signed operand
- DATA_WIDTH, 16, width of the signed input value; must be greater than OPERAND_WIDTH
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- nar_in  input  DATA_WIDTH  signed value to narrow
- nar_in_valid  input  1  nar_in is presented
- nar_in_ready  output  1  block accepts nar_in this cycle
- nar_sat_en  input  1  sampled with nar_in; 1 = saturate out-of-range values, 0 = truncate
- nar_out  output  OPERAND_WIDTH  narrowed operand
- nar_fits  output  1  nar_in was exactly representable in OPERAND_WIDTH bits
- nar_out_valid  output  1  nar_out/nar_fits hold a result
- nar_out_ready  input  1  consumer takes the result this cycle
- nar_clear  input  1  synchronous clear of nar_ovf_count
- nar_ovf_count  output  8  saturating count of delivered non-fitting results

## Operation
- Handshake: a transfer occurs when valid and ready are both high in the same cycle, on both ports. nar_out_valid, once high, stays high with stable data until it is consumed.
- Representability: fits when bits [DATA_WIDTH-1 : OPERAND_WIDTH-1] of nar_in are all equal.
- If fits, nar_out = nar_in[OPERAND_WIDTH-1:0]. Round trip holds: sign-extending nar_out gives back nar_in.
- If not fits and nar_sat_en = 1:
  - non-negative input (MSB 0) gives nar_out = max positive, 0x3FF for defaults;
  - negative input gives nar_out = min negative, 0x400 for defaults.
- If not fits and nar_sat_en = 0: nar_out = low OPERAND_WIDTH bits (wrap).
- Two pipeline stages:
  - S1 captures nar_in, nar_sat_en and computes fits.
  - S2 holds the final nar_out and nar_fits.
  - Each stage has its own valid bit.
- Stage advance rule:
  - S2 loads when S2 is empty or nar_out_ready = 1.
  - S1 loads when S1 is empty or S1 moves into S2.
  - nar_in_ready = !s1_valid || !s2_valid || nar_out_ready. This is a combinational path from nar_out_ready.
- Counter: increments by 1 on each output transfer with nar_fits = 0, and saturates at 255.
  - nar_clear = 1 forces the count to 0 on the next edge.
  - If nar_clear and an increment occur in the same cycle, clear wins.

## Timing
- Latency: an input accepted in cycle t gives nar_out_valid = 1 in cycle t+2, provided S2 is free.
- Throughput: one result per cycle while nar_out_ready = 1.
- Full pipeline with nar_out_ready = 0: both stages valid and nar_in_ready = 0. Nothing is dropped or overwritten.
- Full pipeline with nar_out_ready = 1: a simultaneous output pop and input push is allowed, with no bubble.
- Order is strictly preserved.
- Reset values: s1_valid = 0, s2_valid = 0, nar_out_valid = 0, nar_out = 0, nar_fits = 0, nar_ovf_count = 0. nar_in_ready = 1 in the first cycle after reset.
- Reset mid-operation: all in-flight results are discarded and not counted. Reset dominates nar_clear and any handshake in the same cycle.
- nar_sat_en is meaningful only during an input transfer. It is carried with the data, so changing it later does not affect results already in flight.

## Structure
- Shared package narrow_pkg:
  - counter width constant CNT_WIDTH = 8;
  - function fits_check(value);
  - function sat_value(sign) returning the max/min OPERAND_WIDTH constants.
- One sub-module, narrow_stage: a parameterized valid/ready pipeline register. It is instantiated twice, with payload = {data, sat_en, fits} in S1 and {nar_out, nar_fits} in S2.
- The top level holds the narrowing/saturation logic between the stages and the overflow counter.

## Test plan
- Apply 0x03FF, then 0xFC00, with sat off and out_ready = 1 -> outputs 0x3FF fits=1, then 0x400 fits=1, each 2 cycles after acceptance; count stays 0.
- Apply 0x0400 sat on, 0x0400 sat off, 0xFBFF sat on, 0x7FFF sat on -> outputs 0x3FF/0, 0x400/0, 0x400/0, 0x3FF/0; count = 4.
- Backpressure: offer 5 back-to-back values while out_ready = 0 for 6 cycles -> exactly 2 accepted, nar_in_ready = 0 afterwards, output held stable. Release -> all 5 delivered in order, no duplicates.
- Stream 300 out-of-range values -> count reaches 255 and holds. Assert nar_clear on a cycle with an overflow transfer -> count = 0 next cycle.
- Reset asserted with both stages full and count = 7 -> next cycle nar_out_valid = 0, count = 0, nar_in_ready = 1. A post-reset input appears 2 cycles after acceptance.
- Random signed inputs, checked against a reference model: if fits, sign-extend(nar_out) == nar_in. The model matches nar_out, nar_fits and nar_ovf_count for both nar_sat_en values under random nar_out_ready.

Source files
------------

// File: rtl/narrow_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : narrow_pkg
//  Description : Shared constants and helper functions for operand_narrow.
//                Range check and saturation constants for narrowing a
//                signed value into a smaller signed operand field.
//  Revision    : 1.0 - initial release
// ============================================================================
package narrow_pkg;

   // Width of the overflow event counter
   localparam int CNT_WIDTH = 8;

   // Widest value the helper functions accept; callers sign-extend into it
   localparam int MAX_WIDTH = 64;

   // A value fits in ow signed bits when every bit from ow-1 upwards equals
   // the sign bit. The caller sign-extends its value to MAX_WIDTH, so
   // checking up to the top of the wide vector is the same as checking up
   // to the original MSB.
   function automatic logic fits_check(input logic [MAX_WIDTH-1:0] value,
                                       input int ow);
      logic r_fit;
      r_fit = 1'b1;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         if ((i >= ow - 1) && (value[i] != value[MAX_WIDTH-1])) begin
            r_fit = 1'b0;
         end
      end
      return r_fit;
   endfunction

   // Saturation target: largest positive ow-bit value for a non-negative
   // input, most negative ow-bit value for a negative input. Returned
   // sign-extended to MAX_WIDTH; the caller keeps the low ow bits.
   function automatic logic [MAX_WIDTH-1:0] sat_value(input logic sign,
                                                      input int   ow);
      logic [MAX_WIDTH-1:0] w_max_pos;
      w_max_pos = (MAX_WIDTH'(1) << (ow - 1)) - MAX_WIDTH'(1);
      return sign ? ~w_max_pos : w_max_pos;
   endfunction

endpackage
`default_nettype wire

// File: rtl/operand_narrow_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_narrow_if
//  Description : Input/output handshake bundle of the operand narrowing unit.
//                slave = narrowing unit view, master = producer/consumer view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface operand_narrow_if #(
   parameter int OPERAND_WIDTH = 11,
   parameter int DATA_WIDTH    = 16
);
   import narrow_pkg::*;

   logic [DATA_WIDTH-1:0]    nar_in;
   logic                     nar_in_valid;
   logic                     nar_in_ready;
   logic                     nar_sat_en;
   logic [OPERAND_WIDTH-1:0] nar_out;
   logic                     nar_fits;
   logic                     nar_out_valid;
   logic                     nar_out_ready;
   logic                     nar_clear;
   logic [CNT_WIDTH-1:0]     nar_ovf_count;

   modport slave (
      input  nar_in, nar_in_valid, nar_sat_en, nar_out_ready, nar_clear,
      output nar_in_ready, nar_out, nar_fits, nar_out_valid, nar_ovf_count
   );

   modport master (
      output nar_in, nar_in_valid, nar_sat_en, nar_out_ready, nar_clear,
      input  nar_in_ready, nar_out, nar_fits, nar_out_valid, nar_ovf_count
   );

endinterface
`default_nettype wire

// File: rtl/narrow_stage.sv
`default_nettype none
// ============================================================================
//  Module      : narrow_stage
//  Description : One valid/ready pipeline register. Loads whenever it is
//                empty or its content is being taken downstream, so a full
//                pipeline can push and pop in the same cycle without a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module narrow_stage #(
   parameter int WIDTH = 1
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_valid,
   output logic                  o_ready,
   input  wire logic [WIDTH-1:0] i_data,
   output logic                  o_valid,
   input  wire logic             i_ready,
   output logic [WIDTH-1:0]      o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             w_load;

   assign w_load  = !r_valid || i_ready;
   assign o_ready = w_load;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   // Capture upstream data when free; the valid bit follows upstream valid
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_load) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/operand_narrow.sv
`default_nettype none
// ============================================================================
//  Module      : operand_narrow
//  Description : Two-stage pipelined narrowing of a signed DATA_WIDTH value
//                to a signed OPERAND_WIDTH operand. Reports representability,
//                truncates or saturates out-of-range values, and counts
//                delivered non-fitting results.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_narrow #(
   parameter int OPERAND_WIDTH = 11,
   parameter int DATA_WIDTH    = 16
) (
   input  wire logic        clk,
   input  wire logic        reset,
   operand_narrow_if.slave  bus
);
   import narrow_pkg::*;

   localparam int c_S1_W = DATA_WIDTH + 2;
   localparam int c_S2_W = OPERAND_WIDTH + 1;

   logic                     w_in_fits;
   logic [c_S1_W-1:0]        w_s1_pack;
   logic [c_S1_W-1:0]        w_s1_data;
   logic                     w_s1_valid;
   logic                     w_s2_ready;
   logic [DATA_WIDTH-1:0]    w_s1_in;
   logic                     w_s1_sat;
   logic                     w_s1_fits;
   logic [OPERAND_WIDTH-1:0] w_sat;
   logic [OPERAND_WIDTH-1:0] w_nar_out;
   logic [c_S2_W-1:0]        w_s2_pack;
   logic [c_S2_W-1:0]        w_s2_data;
   logic                     w_s2_valid;
   logic                     w_unused_s1;
   logic                     w_ovf_xfer;
   logic [CNT_WIDTH-1:0]     r_ovf_count;

   // Representability is decided on the raw input, before S1
   assign w_in_fits = fits_check(MAX_WIDTH'(signed'(bus.nar_in)), OPERAND_WIDTH);
   assign w_s1_pack = {bus.nar_in, bus.nar_sat_en, w_in_fits};

   narrow_stage #(.WIDTH(c_S1_W)) u_s1 (
      .clk     (clk),
      .reset   (reset),
      .i_valid (bus.nar_in_valid),
      .o_ready (bus.nar_in_ready),
      .i_data  (w_s1_pack),
      .o_valid (w_s1_valid),
      .i_ready (w_s2_ready),
      .o_data  (w_s1_data)
   );

   assign w_s1_in   = w_s1_data[c_S1_W-1:2];
   assign w_s1_sat  = w_s1_data[1];
   assign w_s1_fits = w_s1_data[0];

   // Only the sign and the low field of the carried value feed the result
   assign w_unused_s1 = ^w_s1_in;

   // Fitting values and wrap mode both keep the low bits; saturation replaces
   // them with the extreme of the input's sign
   assign w_sat     = OPERAND_WIDTH'(sat_value(w_s1_in[DATA_WIDTH-1], OPERAND_WIDTH));
   assign w_nar_out = (!w_s1_fits && w_s1_sat) ? w_sat : w_s1_in[OPERAND_WIDTH-1:0];
   assign w_s2_pack = {w_nar_out, w_s1_fits};

   narrow_stage #(.WIDTH(c_S2_W)) u_s2 (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_s1_valid),
      .o_ready (w_s2_ready),
      .i_data  (w_s2_pack),
      .o_valid (w_s2_valid),
      .i_ready (bus.nar_out_ready),
      .o_data  (w_s2_data)
   );

   assign bus.nar_out       = w_s2_data[c_S2_W-1:1];
   assign bus.nar_fits      = w_s2_data[0];
   assign bus.nar_out_valid = w_s2_valid;

   assign w_ovf_xfer = w_s2_valid && bus.nar_out_ready && !w_s2_data[0];

   // Saturating count of delivered non-fitting results; clear beats increment
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf_count <= '0;
      end else if (bus.nar_clear) begin
         r_ovf_count <= '0;
      end else if (w_ovf_xfer && (r_ovf_count != {CNT_WIDTH{1'b1}})) begin
         r_ovf_count <= r_ovf_count + CNT_WIDTH'(1);
      end
   end

   assign bus.nar_ovf_count = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_operand_narrow.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_narrow
//  Description : Scoreboard bench for operand_narrow with an arithmetic
//                reference model, directed corner cases and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_narrow;

   localparam int OW  = 11;
   localparam int DW  = 16;
   localparam int LIM = 1 << (OW - 1);

   typedef struct {
      logic [OW-1:0] out;
      logic          fits;
      logic [DW-1:0] din;
      int            cyc;
      bit            lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   operand_narrow_if #(.OPERAND_WIDTH(OW), .DATA_WIDTH(DW)) bus ();

   operand_narrow #(.OPERAND_WIDTH(OW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   mon_en   = 1'b0;
   bit   lat_mode = 1'b0;
   int   rdy_mode = 1;
   int   m_cnt    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference: plain signed-integer range test and saturation targets
   function automatic void model(input logic [DW-1:0] x, input bit sat,
                                 output logic [OW-1:0] o, output logic f);
      int v;
      v = int'($signed(x));
      if (v >= -LIM && v < LIM) begin
         f = 1'b1;
         o = OW'(v);
      end else begin
         f = 1'b0;
         if (sat) o = (v < 0) ? OW'(-LIM) : OW'(LIM - 1);
         else     o = OW'(v);
      end
   endfunction

   // Consumer ready: held low, held high, or random per cycle
   initial begin
      bus.nar_out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       bus.nar_out_ready = 1'b0;
            1:       bus.nar_out_ready = 1'b1;
            default: bus.nar_out_ready = 1'($urandom % 2);
         endcase
      end
   end

   // Acceptance side of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && !rst && bus.nar_in_valid && bus.nar_in_ready) begin
            model(bus.nar_in, bus.nar_sat_en, e.out, e.fits);
            e.din = bus.nar_in;
            e.cyc = cyc;
            e.lat = lat_mode;
            q.push_back(e);
         end
      end
   end

   // Output side of the scoreboard plus the counter model
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("ovf_count", 32'(bus.nar_ovf_count), 32'(m_cnt));
            if (rst) begin
               q.delete();
               m_cnt = 0;
            end else begin
               if (bus.nar_out_valid && bus.nar_out_ready) begin
                  if (q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_output: got=0x%0h expected=none", bus.nar_out);
                  end else begin
                     e = q.pop_front();
                     check("nar_out", 32'(bus.nar_out), 32'(e.out));
                     check("nar_fits", 32'(bus.nar_fits), 32'(e.fits));
                     if (e.fits)
                        check("roundtrip", 32'({{(DW-OW){bus.nar_out[OW-1]}}, bus.nar_out}), 32'(e.din));
                     if (e.lat)
                        check("latency", 32'(cyc - e.cyc), 32'd2);
                     if (!e.fits && m_cnt < 255) m_cnt = m_cnt + 1;
                  end
               end
               if (bus.nar_clear) m_cnt = 0;
            end
         end
      end
   end

   task automatic send(input logic [DW-1:0] v, input bit s);
      int n;
      n = 0;
      bus.nar_in       = v;
      bus.nar_sat_en   = s;
      bus.nar_in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.nar_in_ready) break;
         n++;
         if (n > 200) begin
            check("send_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.nar_in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q.size() != 0 || bus.nar_out_valid) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 500) check("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [DW-1:0] b  [5];
      bit            bs [5];
      logic [DW-1:0] corner [8];
      logic [OW-1:0] e_out;
      logic          e_fit;
      int            idx;
      bit            acc;
      logic [DW-1:0] v;

      rst              = 1'b1;
      bus.nar_in       = '0;
      bus.nar_in_valid = 1'b0;
      bus.nar_sat_en   = 1'b0;
      bus.nar_clear    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_out_valid", 32'(bus.nar_out_valid), 32'd0);
      check("rst_nar_out", 32'(bus.nar_out), 32'd0);
      check("rst_fits", 32'(bus.nar_fits), 32'd0);
      check("rst_count", 32'(bus.nar_ovf_count), 32'd0);
      check("rst_in_ready", 32'(bus.nar_in_ready), 32'd1);
      mon_en = 1'b1;

      // Boundary values that just fit
      lat_mode = 1'b1;
      send(16'h03FF, 1'b0);
      send(16'hFC00, 1'b0);
      wait_drain();
      lat_mode = 1'b0;
      check("count_fit", 32'(bus.nar_ovf_count), 32'd0);

      // Values just outside the range, saturated and wrapped
      send(16'h0400, 1'b1);
      send(16'h0400, 1'b0);
      send(16'hFBFF, 1'b1);
      send(16'h7FFF, 1'b1);
      wait_drain();
      check("count_ovf4", 32'(bus.nar_ovf_count), 32'd4);

      // Backpressure: consumer stalled for six cycles
      b[0] = 16'h0012; bs[0] = 1'b0;
      b[1] = 16'hF800; bs[1] = 1'b1;
      b[2] = 16'h0100; bs[2] = 1'b0;
      b[3] = 16'h7000; bs[3] = 1'b0;
      b[4] = 16'hFFFF; bs[4] = 1'b1;
      rdy_mode = 0;
      idx = 0;
      bus.nar_in       = b[0];
      bus.nar_sat_en   = bs[0];
      bus.nar_in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         acc = bus.nar_in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            idx++;
            bus.nar_in     = b[idx];
            bus.nar_sat_en = bs[idx];
         end
      end
      model(b[0], bs[0], e_out, e_fit);
      check("bp_accepted", 32'(idx), 32'd2);
      check("bp_in_ready", 32'(bus.nar_in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.nar_out_valid), 32'd1);
      check("bp_out_held", 32'(bus.nar_out), 32'(e_out));
      bus.nar_in_valid = 1'b0;
      rdy_mode = 1;
      for (int k = idx; k < 5; k++) send(b[k], bs[k]);
      wait_drain();
      check("count_bp", 32'(bus.nar_ovf_count), 32'd6);

      // Counter saturation
      bus.nar_clear = 1'b1;
      @(posedge clk);
      #1;
      bus.nar_clear = 1'b0;
      for (int k = 0; k < 300; k++) begin
         v = {2'b01, 14'($urandom)};
         if ($urandom % 2) v = {2'b10, 14'($urandom)};
         send(v, 1'($urandom % 2));
      end
      wait_drain();
      check("count_sat", 32'(bus.nar_ovf_count), 32'd255);

      // Clear on the same cycle as an overflow transfer
      send(16'h7FFF, 1'b1);
      @(posedge clk);
      #1;
      check("clr_xfer_valid", 32'(bus.nar_out_valid), 32'd1);
      bus.nar_clear = 1'b1;
      @(posedge clk);
      #1;
      bus.nar_clear = 1'b0;
      check("clr_wins", 32'(bus.nar_ovf_count), 32'd0);
      wait_drain();

      // Reset with a full pipeline and a count of 7
      for (int k = 0; k < 7; k++) send(16'h8000, 1'b0);
      wait_drain();
      check("count_7", 32'(bus.nar_ovf_count), 32'd7);
      rdy_mode = 0;
      send(16'h0001, 1'b0);
      send(16'h0002, 1'b0);
      check("full_in_ready", 32'(bus.nar_in_ready), 32'd0);
      check("full_out_valid", 32'(bus.nar_out_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_valid", 32'(bus.nar_out_valid), 32'd0);
      check("mid_rst_count", 32'(bus.nar_ovf_count), 32'd0);
      check("mid_rst_ready", 32'(bus.nar_in_ready), 32'd1);
      rdy_mode = 1;
      lat_mode = 1'b1;
      send(16'hFF85, 1'b1);
      wait_drain();
      lat_mode = 1'b0;

      // Random traffic under random consumer readiness
      corner[0] = 16'h03FF; corner[1] = 16'h0400; corner[2] = 16'hFC00;
      corner[3] = 16'hFBFF; corner[4] = 16'h7FFF; corner[5] = 16'h8000;
      corner[6] = 16'h0000; corner[7] = 16'hFFFF;
      rdy_mode = 2;
      for (int k = 0; k < 400; k++) begin
         case ($urandom % 3)
            0:       v = 16'($urandom);
            1:       v = 16'($urandom_range(0, 2 * LIM - 1)) - 16'(LIM);
            default: v = corner[$urandom % 8];
         endcase
         send(v, 1'($urandom % 2));
      end
      @(posedge clk);
      #1;
      rdy_mode = 1;
      wait_drain();
      check("queue_empty", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
